// File: rtl/cpu.sv
// cpu: single-cycle 16-bit Harvard core, 64K-word instruction ROM and data RAM,
// sixteen registers with r15 doubling as the link register.
module cpu_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  input  logic [3:0]  wa,
  input  logic        we,
  input  logic [15:0] wd,
  output logic [15:0] qa,
  output logic [15:0] qb,
  output logic [15:0] qc
);
  logic [15:0] MEM [0:14];
  logic [15:0] r15;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 15; i++) MEM[i] <= '0;
      r15 <= '0;
    end else if (we) begin
      if (wa == 4'd15) r15 <= wd;
      else MEM[wa] <= wd;
    end
  assign qa = ra == 4'd15 ? r15 : MEM[ra];
  assign qb = rb == 4'd15 ? r15 : MEM[rb];
  assign qc = rc == 4'd15 ? r15 : MEM[rc];
endmodule

module cpu_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wd,
  output logic [15:0] q
);
  logic [15:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = '0;
  always_ff @(posedge clk)
    if (we) mem[addr] <= wd;
  assign q = mem[addr];
endmodule

module cpu (
  input logic clk,
  input logic reset
);
  logic [15:0] imem [0:65535];
  logic [15:0] pc, instr, pc1, npc, a, b, d, s4, s8, s12, ea, rdata, wd;
  logic [3:0]  op, wa;
  logic        we, halt;
  initial for (int i = 0; i < 65536; i++) imem[i] = 16'hF000;
  assign instr = imem[pc];
  assign op    = instr[15:12];
  assign s4    = {{12{instr[3]}}, instr[3:0]};
  assign s8    = {{8{instr[7]}}, instr[7:0]};
  assign s12   = {{4{instr[11]}}, instr[11:0]};
  assign pc1   = pc + 16'd1;
  assign ea    = a + s4;
  assign halt  = instr == 16'hE7FF;
  assign we    = op <= 4'h9 || op == 4'hD;
  assign wa    = op == 4'hD ? 4'd15 : instr[11:8];
  always_comb begin
    wd  = op == 4'h0 ? a + b :
          op == 4'h1 ? a - b :
          op == 4'h2 ? a & b :
          op == 4'h3 ? a | b :
          op == 4'h4 ? a ^ b :
          op == 4'h5 ? a << b[3:0] :
          op == 4'h6 ? a >> b[3:0] :
          op == 4'h7 ? d + s8 :
          op == 4'h8 ? s8 :
          op == 4'h9 ? rdata : pc1;
    npc = (op == 4'hB && d == a) || (op == 4'hC && d != a) ? pc1 + s4 :
          op == 4'hD ? pc1 + s12 :
          op == 4'hE ? (halt ? pc : a) : pc1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= '0;
    else pc <= npc;
  cpu_regs registers (
    .clk(clk), .reset(reset), .ra(instr[7:4]), .rb(instr[3:0]), .rc(instr[11:8]),
    .wa(wa), .we(we), .wd(wd), .qa(a), .qb(b), .qc(d)
  );
  // the reset gate keeps a store from landing on an edge that arrives while reset is held
  cpu_dmem dataMemory (
    .clk(clk), .we(reset && op == 4'hA), .addr(ea), .wd(d), .q(rdata)
  );
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed and random programs run against an instruction-level interpreter.
module tb_cpu;
  logic clk = 0, reset = 0;
  int checks = 0, errors = 0;
  logic [15:0] im [0:65535];
  logic [15:0] M [0:65535];
  logic [15:0] R [0:15];
  logic [15:0] mpc;

  cpu dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rdreg(input int k);
    return k == 15 ? dut.registers.r15 : dut.registers.MEM[k[3:0]];
  endfunction

  task automatic put(input int addr, input logic [15:0] v);
    im[addr] = v;
    dut.imem[addr] = v;
  endtask

  task automatic step();
    logic [15:0] i, a, b, d, npc, s4, s8, s12, ea;
    int rd;
    i = im[mpc];
    rd = int'(i[11:8]);
    a = R[i[7:4]];
    b = R[i[3:0]];
    d = R[rd];
    s4 = {{12{i[3]}}, i[3:0]};
    s8 = {{8{i[7]}}, i[7:0]};
    s12 = {{4{i[11]}}, i[11:0]};
    ea = a + s4;
    npc = mpc + 16'd1;
    case (i[15:12])
      4'h0: R[rd] = a + b;
      4'h1: R[rd] = a - b;
      4'h2: R[rd] = a & b;
      4'h3: R[rd] = a | b;
      4'h4: R[rd] = a ^ b;
      4'h5: R[rd] = a << b[3:0];
      4'h6: R[rd] = a >> b[3:0];
      4'h7: R[rd] = d + s8;
      4'h8: R[rd] = s8;
      4'h9: R[rd] = M[ea];
      4'hA: M[ea] = d;
      4'hB: if (d == a) npc = npc + s4;
      4'hC: if (d != a) npc = npc + s4;
      4'hD: begin R[15] = npc; npc = npc + s12; end
      4'hE: npc = i == 16'hE7FF ? mpc : a;
      default: ;
    endcase
    mpc = npc;
  endtask

  task automatic chk_state();
    chk("pc", dut.pc, mpc);
    chk("instr", dut.instr, im[mpc]);
    for (int k = 0; k < 16; k++) chk($sformatf("r%0d", k), rdreg(k), R[k]);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      step();
      @(negedge clk);
      chk_state();
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = -1;
    for (int k = 0; k < 65536; k++)
      if (bad < 0 && dut.dataMemory.mem[k] !== M[k]) bad = k;
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL %s addr=%0d got=%h exp=%h", tag, bad, dut.dataMemory.mem[bad], M[bad]);
    end
  endtask

  // assert reset between edges, check it bites at once, release on a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 0;
    #1;
    for (int k = 0; k < 16; k++) R[k] = '0;
    mpc = '0;
    chk("rst_pc", dut.pc, 16'h0000);
    for (int k = 0; k < 16; k++) chk($sformatf("rst_r%0d", k), rdreg(k), 16'h0000);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #1;
    for (int k = 0; k < 65536; k++) begin
      put(k, 16'hF000);
      M[k] = '0;
    end
    put(0, 16'h8105); put(1, 16'h82FD); put(2, 16'h0312); put(3, 16'hE7FF);
    do_reset();
    cyc(6);
    chk("add_r3", rdreg(3), 16'h0002);
    chk("add_r2", rdreg(2), 16'hFFFD);
    chk("halt_instr", dut.instr, 16'hE7FF);
    chk("halt_pc", dut.pc, 16'h0003);

    put(0, 16'h847F); put(1, 16'hA402); put(2, 16'h9502); put(3, 16'hE7FF);
    do_reset();
    cyc(5);
    chk("sw_mem2", dut.dataMemory.mem[2], 16'h007F);
    chk("lw_r5", rdreg(5), 16'h007F);
    chk_mem("sw_mem");

    put(0, 16'h8103); put(1, 16'h71FF); put(2, 16'hC10E); put(3, 16'hE7FF);
    do_reset();
    cyc(7);
    chk("loop_pc", dut.pc, 16'h0003);
    chk("loop_r1", rdreg(1), 16'h0000);
    cyc(3);
    chk("loop_hold", dut.pc, 16'h0003);

    for (int k = 0; k < 4; k++) put(k, 16'hF000);
    put(4, 16'hD001); put(5, 16'hE7FF); put(6, 16'hE0F0);
    do_reset();
    cyc(5);
    chk("jal_r15", rdreg(15), 16'h0005);
    chk("jal_pc", dut.pc, 16'h0006);
    cyc(1);
    chk("jr_pc", dut.pc, 16'h0005);
    cyc(2);

    put(0, 16'h81FF); put(1, 16'h7101); put(2, 16'h5210); put(3, 16'hE7FF);
    do_reset();
    cyc(5);
    chk("wrap_r1", rdreg(1), 16'h0000);
    chk("sll_r2", rdreg(2), 16'h0000);

    put(0, 16'h8101); put(1, 16'h7101); put(2, 16'hA105); put(3, 16'hB00D);
    do_reset();
    cyc(10);
    do_reset();
    chk_mem("rst_mem");
    cyc(9);
    chk_mem("rerun_mem");

    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 64; k++) put(k, 16'($urandom));
      do_reset();
      cyc(150);
      chk_mem($sformatf("rand%0d_mem", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
